// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared phase encoding and default phase durations for
//            traffic_light_ctrl_n.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10,
        PH_WALK    = 2'b11
    } phase_e;

    localparam int DEF_NUM_DIR       = 4;
    localparam int DEF_GREEN_CYCLES  = 8;
    localparam int DEF_YELLOW_CYCLES = 3;
    localparam int DEF_ALLRED_CYCLES = 2;
    localparam int DEF_WALK_CYCLES   = 6;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_DIR_W         = 3;

endpackage : traffic_pkg

`default_nettype wire

// File: rtl/rr_next_dir.sv
// ============================================================================
// Module   : rr_next_dir
// Purpose  : Combinational rotating-priority selector. Picks the first set
//            request after cur (cur itself last); cur+1 when nothing is set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_next_dir #(
    parameter int NUM_DIR = 4,
    parameter int DIR_W   = 3
) (
    input  logic [NUM_DIR-1:0] req,
    input  logic [DIR_W-1:0]   cur,
    output logic [DIR_W-1:0]   next_idx
);

    int w_best;
    int w_best_d;
    int w_dist;

    // Each candidate is ranked by its cyclic distance from cur+1; smallest wins.
    always_comb begin
        w_best   = (int'(cur) + 1) % NUM_DIR;
        w_best_d = NUM_DIR;
        w_dist   = 0;
        for (int i = 0; i < NUM_DIR; i++) begin
            w_dist = (i - int'(cur) - 1 + 2 * NUM_DIR) % NUM_DIR;
            if (req[i] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_best   = i;
            end
        end
        next_idx = DIR_W'(w_best);
    end

endmodule : rr_next_dir

`default_nettype wire

// File: rtl/traffic_light_ctrl_n.sv
// ============================================================================
// Module   : traffic_light_ctrl_n
// Purpose  : N-approach traffic light sequencer (GREEN/YELLOW/ALL_RED) with
//            round-robin, sensor-skipping approach selection. Optional
//            pedestrian WALK phase enabled by macro TRAFFIC_PED_WALK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl_n
    import traffic_pkg::*;
#(
    parameter int NUM_DIR       = DEF_NUM_DIR,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int DIR_W         = DEF_DIR_W
`ifdef TRAFFIC_PED_WALK_EN
    ,
    parameter int WALK_CYCLES   = DEF_WALK_CYCLES
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DIR-1:0] car_present,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [DIR_W-1:0]   active_dir,
    output logic [1:0]         phase
`ifdef TRAFFIC_PED_WALK_EN
    ,
    input  logic               ped_req,
    output logic               walk
`endif
);

    localparam logic [CNT_W-1:0] c_green_load  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_yellow_load = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_allred_load = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [DIR_W-1:0] c_dir_rst     = DIR_W'(NUM_DIR - 1);
`ifdef TRAFFIC_PED_WALK_EN
    localparam logic [CNT_W-1:0] c_walk_load   = CNT_W'(WALK_CYCLES - 1);
`endif

    phase_e             r_state;
    phase_e             w_state_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_n;
    logic [DIR_W-1:0]   r_dir;
    logic [DIR_W-1:0]   w_dir_n;
    logic [DIR_W-1:0]   w_rr_dir;
    logic [NUM_DIR-1:0] r_red,    w_red_n;
    logic [NUM_DIR-1:0] r_yellow, w_yellow_n;
    logic [NUM_DIR-1:0] r_green,  w_green_n;
`ifdef TRAFFIC_PED_WALK_EN
    logic               r_ped_latch, w_ped_latch_n;
    logic               r_walk,      w_walk_n;
`endif

    rr_next_dir #(
        .NUM_DIR (NUM_DIR),
        .DIR_W   (DIR_W)
    ) u_rr_next_dir (
        .req      (car_present),
        .cur      (r_dir),
        .next_idx (w_rr_dir)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= PH_ALL_RED;
            r_cnt    <= c_allred_load;
            r_dir    <= c_dir_rst;
            r_red    <= '1;
            r_yellow <= '0;
            r_green  <= '0;
`ifdef TRAFFIC_PED_WALK_EN
            r_ped_latch <= 1'b0;
            r_walk      <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_dir    <= w_dir_n;
            r_red    <= w_red_n;
            r_yellow <= w_yellow_n;
            r_green  <= w_green_n;
`ifdef TRAFFIC_PED_WALK_EN
            r_ped_latch <= w_ped_latch_n;
            r_walk      <= w_walk_n;
`endif
        end
    end

    // Next-state logic; lamps are decoded from the next state so they are
    // registered alongside it and change in the same cycle as phase.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt - CNT_W'(1);
        w_dir_n    = r_dir;
        w_green_n  = '0;
        w_yellow_n = '0;
`ifdef TRAFFIC_PED_WALK_EN
        w_ped_latch_n = r_ped_latch | ped_req;
`endif
        case (r_state)
            PH_ALL_RED: begin
                if (r_cnt == '0) begin
`ifdef TRAFFIC_PED_WALK_EN
                    if (r_ped_latch) begin
                        w_state_n     = PH_WALK;
                        w_cnt_n       = c_walk_load;
                        w_ped_latch_n = ped_req;
                    end else
`endif
                    begin
                        w_state_n = PH_GREEN;
                        w_cnt_n   = c_green_load;
                        w_dir_n   = w_rr_dir;
                    end
                end
            end
            PH_GREEN: begin
                if (r_cnt == '0) begin
                    w_state_n = PH_YELLOW;
                    w_cnt_n   = c_yellow_load;
                end
            end
            PH_YELLOW: begin
                if (r_cnt == '0) begin
                    w_state_n = PH_ALL_RED;
                    w_cnt_n   = c_allred_load;
                end
            end
`ifdef TRAFFIC_PED_WALK_EN
            PH_WALK: begin
                if (r_cnt == '0) begin
                    w_state_n = PH_ALL_RED;
                    w_cnt_n   = c_allred_load;
                end
            end
`endif
            default: begin
                w_state_n = PH_ALL_RED;
                w_cnt_n   = c_allred_load;
            end
        endcase

        for (int i = 0; i < NUM_DIR; i++) begin
            w_green_n[i]  = (w_state_n == PH_GREEN)  && (w_dir_n == DIR_W'(i));
            w_yellow_n[i] = (w_state_n == PH_YELLOW) && (w_dir_n == DIR_W'(i));
        end
        w_red_n = ~(w_green_n | w_yellow_n);
`ifdef TRAFFIC_PED_WALK_EN
        w_walk_n = (w_state_n == PH_WALK);
`endif
    end

    assign red        = r_red;
    assign yellow     = r_yellow;
    assign green      = r_green;
    assign active_dir = r_dir;
    assign phase      = r_state;
`ifdef TRAFFIC_PED_WALK_EN
    assign walk       = r_walk;
`endif

endmodule : traffic_light_ctrl_n

`default_nettype wire

// File: tb/tb_traffic_light_ctrl_n.sv
// ============================================================================
// Module   : tb_traffic_light_ctrl_n
// Purpose  : Directed self-checking bench for traffic_light_ctrl_n (default
//            parameters, TRAFFIC_PED_WALK_EN undefined).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl_n;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] car_present = 4'b1111;
    logic [3:0] red, yellow, green;
    logic [2:0] active_dir;
    logic [1:0] phase;

    int vectors     = 0;
    int miscompares = 0;
    bit inv_en      = 1'b0;

    always #5 clk = ~clk;

    traffic_light_ctrl_n #(
        .NUM_DIR       (4),
        .GREEN_CYCLES  (8),
        .YELLOW_CYCLES (3),
        .ALLRED_CYCLES (2),
        .CNT_W         (8),
        .DIR_W         (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .car_present (car_present),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .active_dir  (active_dir),
        .phase       (phase)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at k=0: the cycle right after the reset edge.
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Timing with 8/3/2 after reset: 2 all-red, then 13-cycle G/Y/R slots.
    function automatic logic [1:0] exp_phase(int k);
        int m;
        if (k < 2) return 2'b00;
        m = (k - 2) % 13;
        if (m < 8)  return 2'b01;
        if (m < 11) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [16:0] exp_vec(int k, logic [2:0] dir);
        logic [1:0] ph;
        logic [3:0] g, y, one;
        ph  = exp_phase(k);
        one = 4'b0001 << dir;
        g   = (ph == 2'b01) ? one : 4'b0000;
        y   = (ph == 2'b10) ? one : 4'b0000;
        return {ph, dir, ~(g | y), y, g};
    endfunction

    always @(negedge clk) begin
        if (inv_en) begin
            vectors++;
            if (!(($countones(green | yellow) <= 1) && (red === ~(green | yellow)))) begin
                miscompares++;
                $display("FAIL invariant t=%0t: red=%b yellow=%b green=%b", $time, red, yellow, green);
            end
        end
    end

    task automatic test_reset();
        logic [16:0] exp;
        car_present = 4'b1111;
        do_reset();
        inv_en = 1'b1;
        exp = {2'b00, 3'd3, 4'b1111, 4'b0000, 4'b0000};
        for (int k = 0; k < 2; k++) begin
            if (k > 0) step();
            vectors++;
            if ({phase, active_dir, red, yellow, green} !== exp) begin
                miscompares++;
                $display("FAIL reset k=%0d: got %h expected %h", k,
                         {phase, active_dir, red, yellow, green}, exp);
            end
        end
    endtask

    task automatic test_rotation();
        logic [16:0] exp;
        logic [2:0]  dir;
        car_present = 4'b1111;
        do_reset();
        for (int k = 0; k <= 54; k++) begin
            if (k > 0) step();
            dir = (k < 2) ? 3'd3 : 3'(((k - 2) / 13) % 4);
            exp = exp_vec(k, dir);
            vectors++;
            if ({phase, active_dir, red, yellow, green} !== exp) begin
                miscompares++;
                $display("FAIL rotation k=%0d: got %h expected %h", k,
                         {phase, active_dir, red, yellow, green}, exp);
            end
        end
    endtask

    task automatic test_single_car();
        logic [16:0] exp;
        car_present = 4'b0100;
        do_reset();
        for (int k = 0; k <= 41; k++) begin
            if (k > 0) step();
            exp = exp_vec(k, (k < 2) ? 3'd3 : 3'd2);
            vectors++;
            if ({phase, active_dir, red, yellow, green} !== exp) begin
                miscompares++;
                $display("FAIL single_car k=%0d: got %h expected %h", k,
                         {phase, active_dir, red, yellow, green}, exp);
            end
        end
    endtask

    task automatic test_no_car();
        logic [16:0] exp;
        logic [2:0]  dir;
        car_present = 4'b0000;
        do_reset();
        for (int k = 0; k <= 54; k++) begin
            if (k > 0) step();
            dir = (k < 2) ? 3'd3 : 3'(((k - 2) / 13) % 4);
            exp = exp_vec(k, dir);
            vectors++;
            if ({phase, active_dir, red, yellow, green} !== exp) begin
                miscompares++;
                $display("FAIL no_car k=%0d: got %h expected %h", k,
                         {phase, active_dir, red, yellow, green}, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] exp;
        car_present = 4'b1111;
        do_reset();
        for (int k = 1; k <= 19; k++) step();
        exp = {2'b01, 3'd1, 4'b1101, 4'b0000, 4'b0010};
        vectors++;
        if ({phase, active_dir, red, yellow, green} !== exp) begin
            miscompares++;
            $display("FAIL mid_reset_pre: got %h expected %h",
                     {phase, active_dir, red, yellow, green}, exp);
        end
        do_reset();
        exp = {2'b00, 3'd3, 4'b1111, 4'b0000, 4'b0000};
        vectors++;
        if ({phase, active_dir, red, yellow, green} !== exp) begin
            miscompares++;
            $display("FAIL mid_reset_post: got %h expected %h",
                     {phase, active_dir, red, yellow, green}, exp);
        end
        step();
        step();
        exp = {2'b01, 3'd0, 4'b1110, 4'b0000, 4'b0001};
        vectors++;
        if ({phase, active_dir, red, yellow, green} !== exp) begin
            miscompares++;
            $display("FAIL mid_reset_restart: got %h expected %h",
                     {phase, active_dir, red, yellow, green}, exp);
        end
    endtask

    task automatic test_sensor_change();
        logic [16:0] exp;
        car_present = 4'b0001;
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            if (k == 5) car_present = 4'b1000;
            if (k < 15) exp = exp_vec(k, (k < 2) ? 3'd3 : 3'd0);
            else        exp = {2'b01, 3'd3, 4'b0111, 4'b0000, 4'b1000};
            vectors++;
            if ({phase, active_dir, red, yellow, green} !== exp) begin
                miscompares++;
                $display("FAIL sensor_change k=%0d: got %h expected %h", k,
                         {phase, active_dir, red, yellow, green}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_car();
        test_no_car();
        test_mid_reset();
        test_sensor_change();
        inv_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_traffic_light_ctrl_n

`default_nettype wire

// File: doc/traffic_light_ctrl_n.md
Name: traffic_light_ctrl_n

Overview:
- Parametrised successor to the two-way NS/EW controller.
- Sequences NUM_DIR approaches through GREEN -> YELLOW -> ALL_RED phases, each phase held for a programmed number of cycles.
- Round-robin choice of the next approach; approaches with no vehicle sensed are skipped.
- Standalone leaf block driven by the system clock; no bus interface.

Parameters:
- NUM_DIR, 4, number of approaches (2..8).
- GREEN_CYCLES, 8, green phase length in cycles (>=1).
- YELLOW_CYCLES, 3, yellow phase length in cycles (>=1).
- ALLRED_CYCLES, 2, all-red clearance length in cycles (>=1).
- CNT_W, 8, phase counter width; must hold max(cycles)-1.
- DIR_W, 3, width of active_dir; must satisfy 2**DIR_W >= NUM_DIR.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- car_present  in  NUM_DIR  vehicle sensor per approach; level, sampled on clk.
- red  out  NUM_DIR  red lamp per approach.
- yellow  out  NUM_DIR  yellow lamp per approach.
- green  out  NUM_DIR  green lamp per approach.
- active_dir  out  DIR_W  approach owning the current or last green.
- phase  out  2  00=ALL_RED, 01=GREEN, 10=YELLOW.

Behaviour:
- Reset (synchronous, active-high; one clk edge with reset=1):
  - state=ALL_RED, cnt=ALLRED_CYCLES-1, active_dir=NUM_DIR-1.
  - red=all 1s, green=0, yellow=0, phase=00.
- Reset asserted mid-phase overrides everything at the next edge. Lamps go all-red immediately, with no yellow.
- Counter:
  - On phase entry, load cnt = DURATION-1.
  - Decrement each cycle.
  - Leave the phase on the cycle where cnt==0.
  - Each phase therefore lasts exactly DURATION cycles.
- Transitions:
  - ALL_RED, cnt==0 -> GREEN; active_dir <= next_dir.
  - GREEN, cnt==0 -> YELLOW.
  - YELLOW, cnt==0 -> ALL_RED.
- next_dir:
  - Combinational from car_present and active_dir.
  - Scan active_dir+1, +2, ... NUM_DIR cyclically (wraps modulo NUM_DIR).
  - Pick the first approach with car_present=1. active_dir itself is the last candidate.
  - If no bit is set, next_dir = (active_dir+1) mod NUM_DIR.
  - Sampled only on the final ALL_RED cycle. car_present changes at other times have no effect.
- After reset, the first green is approach 0 if car_present[0]=1 or no car is present. Otherwise it is the first set bit scanning upward from 0.
- Outputs are registered (decoded from state regs, no input-to-output combinational path):
  - green[i] = (phase==GREEN && active_dir==i).
  - yellow[i] = (phase==YELLOW && active_dir==i).
  - red = ~(green|yellow).
- Invariant, every cycle: at most one bit of (green|yellow) set, and red|yellow|green is all 1s.
- Cycle length with every approach served: NUM_DIR*(GREEN_CYCLES+YELLOW_CYCLES+ALLRED_CYCLES).

Optional Feature:
- Macro: TRAFFIC_PED_WALK_EN.
- When defined:
  - Adds input ped_req (1) and output walk (1), plus parameter WALK_CYCLES (default 6).
  - A pulse on ped_req sets a sticky latch.
  - If the latch is set on the final ALL_RED cycle, enter state WALK instead of GREEN. Phase code 11, all red, walk=1, for WALK_CYCLES cycles.
  - The latch clears on WALK entry. WALK then goes to ALL_RED, after which normal selection resumes.
  - active_dir is unchanged by WALK.
  - A ped_req during WALK re-latches for the next opportunity.
  - Reset clears the latch and drives walk=0.
- When undefined: ped_req, walk, WALK_CYCLES and the WALK state do not exist; phase 11 is unreachable.

Decomposition:
- Package traffic_pkg holds:
  - phase enum (PH_ALL_RED=2'b00, PH_GREEN=2'b01, PH_YELLOW=2'b10, PH_WALK=2'b11).
  - Default duration constants.
- One sub-module, rr_next_dir: purely combinational rotating priority selector (inputs req vector and current index; output next index).
- FSM, counter and output decode stay in the top module.

Test Plan (NUM_DIR=4, GREEN=8, YELLOW=3, ALLRED=2, car_present=4'b1111 unless stated):
- Reset 1 cycle, release:
  - red=4'b1111 for 2 cycles.
  - green=4'b0001 for 8 cycles, then yellow=4'b0001 for 3, then all red for 2, then green=4'b0010.
  - One full rotation = 52 cycles.
- car_present=4'b0100 held: after reset green goes to dir 2 only; every subsequent green is dir 2, with ALL_RED/YELLOW between.
- car_present=4'b0000: plain rotation 0,1,2,3,0 (wrap check).
- Reset asserted on the 5th GREEN cycle of dir 1: next cycle red=4'b1111, yellow=0, phase=00, active_dir=3.
- car_present changes 4'b0001 -> 4'b1000 mid-GREEN of dir 0: next green is dir 3.
- Every run: assert one-hot-or-zero on green|yellow and red==~(green|yellow) each cycle.
- TRAFFIC_PED_WALK_EN: ped_req pulse during GREEN dir 0:
  - After its YELLOW and ALL_RED, walk=1 and red=all 1s for 6 cycles.
  - Then 2 ALL_RED cycles, then green dir 1.
